// File: rtl/fdiv.sv
// Single-precision divider: iterative restoring mantissa division,
// fixed latency, truncating rounding, start/busy/done handshake.
module fdiv #(
    parameter int ITERS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        dz
);

    localparam int NCYC = 25 / ITERS_PER_CYCLE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_NORM,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_sign;
    logic [7:0]         r_ea;
    logic [7:0]         r_eb;
    logic [23:0]        r_mb;
    logic [24:0]        r_rem;
    logic [24:0]        r_q;
    logic [4:0]         r_cnt;
    logic               r_spec;
    logic [31:0]        r_spec_res;
    logic               r_spec_dz;
    logic [31:0]        r_out;
    logic               r_dz;

    logic [7:0]         w_a_exp;
    logic [7:0]         w_b_exp;
    logic               w_a_nan;
    logic               w_b_nan;
    logic               w_a_inf;
    logic               w_b_inf;
    logic               w_a_zero;
    logic               w_b_zero;
    logic               w_sign;
    logic               w_spec;
    logic [31:0]        w_spec_res;
    logic               w_spec_dz;

    logic [24:0]        w_rem;
    logic [24:0]        w_q;
    logic               w_last;

    logic signed [9:0]  w_ea10;
    logic signed [9:0]  w_eb10;
    logic signed [9:0]  w_bias;
    logic signed [9:0]  w_e;
    logic [22:0]        w_frac;
    logic [31:0]        w_res;
    logic               w_res_dz;

    assign w_a_exp  = rs1[30:23];
    assign w_b_exp  = rs2[30:23];
    assign w_a_nan  = (&w_a_exp) && (|rs1[22:0]);
    assign w_b_nan  = (&w_b_exp) && (|rs2[22:0]);
    assign w_a_inf  = (&w_a_exp) && !(|rs1[22:0]);
    assign w_b_inf  = (&w_b_exp) && !(|rs2[22:0]);
    // Denormals collapse to zero: no gradual underflow support.
    assign w_a_zero = (w_a_exp == 8'd0);
    assign w_b_zero = (w_b_exp == 8'd0);
    assign w_sign   = rs1[31] ^ rs2[31];
    assign w_last   = (r_cnt == 5'(NCYC - 1));

    // Classify operands at start; first matching special case wins.
    always_comb begin
        w_spec     = 1'b1;
        w_spec_res = 32'h7FC0_0000;
        w_spec_dz  = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) ||
            (w_a_inf && w_b_inf)) begin
            w_spec_res = 32'h7FC0_0000;
        end else if (w_a_inf) begin
            w_spec_res = {w_sign, 8'hFF, 23'h0};
        end else if (w_b_zero) begin
            w_spec_res = {w_sign, 8'hFF, 23'h0};
            w_spec_dz  = 1'b1;
        end else if (w_a_zero || w_b_inf) begin
            w_spec_res = {w_sign, 31'h0};
        end else begin
            w_spec     = 1'b0;
            w_spec_res = 32'h0;
        end
    end

    // Retire ITERS_PER_CYCLE restoring-division steps, MSB first.
    always_comb begin
        w_rem = r_rem;
        w_q   = r_q;
        for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
            if (w_rem >= {1'b0, r_mb}) begin
                w_q   = {w_q[23:0], 1'b1};
                w_rem = w_rem - {1'b0, r_mb};
            end else begin
                w_q   = {w_q[23:0], 1'b0};
            end
            // After a subtract rem < mb, so bit 24 is free to drop.
            w_rem = {w_rem[23:0], 1'b0};
        end
    end

    // Normalise the quotient and saturate the exponent range.
    always_comb begin
        w_ea10   = {2'b00, r_ea};
        w_eb10   = {2'b00, r_eb};
        w_bias   = r_q[24] ? 10'sd127 : 10'sd126;
        w_e      = w_ea10 - w_eb10 + w_bias;
        w_frac   = r_q[24] ? r_q[23:1] : r_q[22:0];
        w_res_dz = r_spec & r_spec_dz;
        if (r_spec) begin
            w_res = r_spec_res;
        end else if (w_e >= 10'sd255) begin
            w_res = {r_sign, 8'hFF, 23'h0};
        end else if (w_e <= 10'sd0) begin
            w_res = {r_sign, 31'h0};
        end else begin
            w_res = {r_sign, w_e[7:0], w_frac};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_DIV;
                end
            end
            S_DIV: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_NORM;
                end
            end
            S_NORM: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration state and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign     <= 1'b0;
            r_ea       <= 8'd0;
            r_eb       <= 8'd0;
            r_mb       <= 24'd0;
            r_rem      <= 25'd0;
            r_q        <= 25'd0;
            r_cnt      <= 5'd0;
            r_spec     <= 1'b0;
            r_spec_res <= 32'h0;
            r_spec_dz  <= 1'b0;
            r_out      <= 32'h0;
            r_dz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign     <= w_sign;
                        r_ea       <= w_a_exp;
                        r_eb       <= w_b_exp;
                        r_mb       <= {1'b1, rs2[22:0]};
                        r_rem      <= {2'b01, rs1[22:0]};
                        r_q        <= 25'd0;
                        r_cnt      <= 5'd0;
                        r_spec     <= w_spec;
                        r_spec_res <= w_spec_res;
                        r_spec_dz  <= w_spec_dz;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem;
                    r_q   <= w_q;
                    r_cnt <= r_cnt + 5'd1;
                end
                S_NORM: begin
                    r_out <= w_res;
                    r_dz  <= w_res_dz;
                end
                default: begin
                end
            endcase
        end
    end

    assign out = r_out;
    assign dz  = r_dz;

endmodule

// File: tb/tb_fdiv.sv
// Directed bench for fdiv: runs 1-bit and 5-bit-per-cycle
// instances side by side on the same stimulus.
module tb_fdiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy1, done1, dz1;
    logic        busy5, done5, dz5;
    logic [31:0] out1, out5;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    fdiv #(.ITERS_PER_CYCLE(1)) u1 (
        .clk(clk), .reset(reset), .start(start),
        .rs1(rs1), .rs2(rs2),
        .busy(busy1), .done(done1), .out(out1), .dz(dz1)
    );

    fdiv #(.ITERS_PER_CYCLE(5)) u5 (
        .clk(clk), .reset(reset), .start(start),
        .rs1(rs1), .rs2(rs2),
        .busy(busy5), .done(done5), .out(out5), .dz(dz5)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One op: start pulse, then 32 cycles with garbage on rs1/rs2.
    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eo,
                          input logic ed);
        int l1, l5, b1, b5, n1, n5;
        l1 = 0; l5 = 0; b1 = 0; b5 = 0; n1 = 0; n5 = 0;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rs1   = $urandom;
            rs2   = $urandom;
            if (busy1) b1++;
            if (busy5) b5++;
            if (done1) begin
                n1++;
                if (l1 == 0) l1 = t;
                chk({tag, " out1"}, out1, eo);
                chk({tag, " dz1"}, 32'(dz1), 32'(ed));
            end
            if (done5) begin
                n5++;
                if (l5 == 0) l5 = t;
                chk({tag, " out5"}, out5, eo);
                chk({tag, " dz5"}, 32'(dz5), 32'(ed));
            end
        end
        chk({tag, " lat1"}, 32'(l1), 32'd27);
        chk({tag, " lat5"}, 32'(l5), 32'd7);
        chk({tag, " ndone1"}, 32'(n1), 32'd1);
        chk({tag, " ndone5"}, 32'(n5), 32'd1);
        chk({tag, " busy1"}, 32'(b1), 32'd26);
        chk({tag, " busy5"}, 32'(b5), 32'd6);
        chk({tag, " hold1"}, out1, eo);
        chk({tag, " hold5"}, out5, eo);
    endtask

    initial begin
        int n1, n5, l1, l5;
        int d1t[4];
        int d5t[4];
        logic [31:0] d1o[4];
        logic [31:0] d5o[4];

        reset = 1'b1;
        start = 1'b0;
        rs1   = 32'h0;
        rs2   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst busy1", 32'(busy1), 32'd0);
        chk("rst done1", 32'(done1), 32'd0);
        chk("rst out1", out1, 32'h0);
        chk("rst dz1", 32'(dz1), 32'd0);
        chk("rst out5", out5, 32'h0);

        run_op("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        run_op("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);
        run_op("1/1", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
        run_op("-8/.5", 32'hC1000000, 32'h3F000000, 32'hC1800000, 1'b0);
        run_op("1/0", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1);
        run_op("-1/-0", 32'hBF800000, 32'h80000000, 32'h7F800000, 1'b1);
        run_op("1/den", 32'h3F800000, 32'h00000001, 32'h7F800000, 1'b1);
        run_op("0/0", 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0);
        run_op("inf/inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0);
        run_op("nan/1", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0);
        run_op("2/inf", 32'h40000000, 32'h7F800000, 32'h00000000, 1'b0);
        run_op("inf/-2", 32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0);
        run_op("inf/0", 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0);
        run_op("-0/2", 32'h80000000, 32'h40000000, 32'h80000000, 1'b0);
        run_op("ovf", 32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0);
        run_op("unf", 32'h00800000, 32'h40000000, 32'h00000000, 1'b0);

        // Second start while busy must be ignored.
        n1 = 0; n5 = 0; l1 = 0; l5 = 0;
        rs1   = 32'h40C00000;
        rs2   = 32'h40000000;
        start = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            @(posedge clk); #1;
            start = (t == 4);
            if (done1) begin n1++; if (l1 == 0) l1 = t; end
            if (done5) begin n5++; if (l5 == 0) l5 = t; end
        end
        chk("busy-start ndone1", 32'(n1), 32'd1);
        chk("busy-start ndone5", 32'(n5), 32'd1);
        chk("busy-start lat1", 32'(l1), 32'd27);
        chk("busy-start lat5", 32'(l5), 32'd7);

        // Reset mid-operation aborts with no done.
        n1 = 0;
        rs1   = 32'h3F800000;
        rs2   = 32'h00000000;
        start = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            reset = (t == 10);
            if (t == 11) begin
                chk("abort busy1", 32'(busy1), 32'd0);
                chk("abort done1", 32'(done1), 32'd0);
                chk("abort out1", out1, 32'h0);
                chk("abort dz1", 32'(dz1), 32'd0);
                chk("abort out5", out5, 32'h0);
                chk("abort dz5", 32'(dz5), 32'd0);
            end
            if (t >= 11 && (done1 || done5)) n1++;
        end
        chk("abort ndone", 32'(n1), 32'd0);

        // Start held high: next op accepted the cycle after done.
        n1 = 0; n5 = 0;
        rs1   = 32'h40C00000;
        rs2   = 32'h40000000;
        start = 1'b1;
        for (int t = 1; t <= 70; t++) begin
            @(posedge clk); #1;
            if (t == 2) begin
                rs1 = 32'h3F800000;
                rs2 = 32'h40400000;
            end
            if (done1 && n1 < 4) begin
                d1t[n1] = t; d1o[n1] = out1; n1++;
            end
            if (done5 && n5 < 4) begin
                d5t[n5] = t; d5o[n5] = out5; n5++;
            end
        end
        start = 1'b0;
        chk("b2b n1", 32'(n1 >= 2), 32'd1);
        chk("b2b n5", 32'(n5 >= 2), 32'd1);
        if (n1 >= 2) begin
            chk("b2b t1a", 32'(d1t[0]), 32'd27);
            chk("b2b t1b", 32'(d1t[1]), 32'd55);
            chk("b2b o1a", d1o[0], 32'h40400000);
            chk("b2b o1b", d1o[1], 32'h3EAAAAAA);
        end
        if (n5 >= 2) begin
            chk("b2b t5a", 32'(d5t[0]), 32'd7);
            chk("b2b t5b", 32'(d5t[1]), 32'd15);
            chk("b2b o5a", d5o[0], 32'h40400000);
            chk("b2b o5b", d5o[1], 32'h3EAAAAAA);
        end

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("final busy1", 32'(busy1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
